// File: rtl/snake_body_tracker.sv
// Snake body engine: segment list in a circular buffer, one move per step with
// wall and self-collision checks, reporting the new head and the vacated tail cell.
module snake_body_tracker #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 4,
  parameter int INIT_Y   = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic           step_valid,
  input  logic [1:0]     step_dir,
  input  logic           grow,
  output logic           step_ready,
  output logic           result_valid,
  output logic           dead,
  output logic           death_cause,
  output logic [XW+YW-1:0] head_xy,
  output logic           erase_valid,
  output logic [XW+YW-1:0] erase_xy,
  output logic [LW-1:0]  length
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD, READY, CHECK, SCAN, COMMIT, DEAD} state_t;

  state_t             state_q;
  logic [XW+YW-1:0]   mem [MAX_LEN];
  logic [PW-1:0]      tail_ptr_q, head_ptr_q, scan_ptr_q, load_cnt_q;
  logic [LW-1:0]      scan_rem_q, length_q;
  logic [1:0]         dir_q, last_dir_q;
  logic               grow_q, result_valid_q, dead_q, cause_q, erase_valid_q;
  logic [XW+YW-1:0]   new_head_q, head_xy_q, erase_xy_q;

  logic [XW-1:0]      hx, nx_d;
  logic [YW-1:0]      hy, ny_d;
  logic               wall_d, eff_grow_d;
  logic [LW-1:0]      n_cmp_d;
  logic               mem_we;
  logic [PW-1:0]      mem_waddr;
  logic [XW+YW-1:0]   mem_wdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
  endfunction

  assign hx = head_xy_q[XW-1:0];
  assign hy = head_xy_q[XW+YW-1:XW];

  always_comb begin
    nx_d   = hx;
    ny_d   = hy;
    wall_d = 1'b0;
    case (dir_q)
      DIR_RIGHT: begin nx_d = hx + XW'(1); wall_d = (hx == XW'(GRID_W - 1)); end
      DIR_DOWN:  begin ny_d = hy + YW'(1); wall_d = (hy == YW'(GRID_H - 1)); end
      DIR_UP:    begin ny_d = hy - YW'(1); wall_d = (hy == '0); end
      default:   begin nx_d = hx - XW'(1); wall_d = (hx == '0); end
    endcase
  end

  // The current tail only counts as body when it stays put, i.e. on an effective grow.
  assign eff_grow_d = grow_q && (length_q < LW'(MAX_LEN));
  assign n_cmp_d    = eff_grow_d ? length_q : length_q - LW'(1);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_inc(head_ptr_q);
    mem_wdata = new_head_q;
    if (!init && state_q == LOAD) begin
      mem_we    = 1'b1;
      mem_waddr = load_cnt_q;
      mem_wdata = {YW'(INIT_Y), XW'(INIT_X - INIT_LEN + 1) + XW'(load_cnt_q)};
    end else if (!init && state_q == COMMIT) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tail_ptr_q     <= '0;
      head_ptr_q     <= '0;
      scan_ptr_q     <= '0;
      load_cnt_q     <= '0;
      scan_rem_q     <= '0;
      length_q       <= '0;
      dir_q          <= DIR_RIGHT;
      last_dir_q     <= DIR_RIGHT;
      grow_q         <= 1'b0;
      result_valid_q <= 1'b0;
      dead_q         <= 1'b0;
      cause_q        <= 1'b0;
      erase_valid_q  <= 1'b0;
      new_head_q     <= '0;
      head_xy_q      <= '0;
      erase_xy_q     <= '0;
    end else begin
      result_valid_q <= 1'b0;
      if (init) begin
        state_q       <= LOAD;
        dead_q        <= 1'b0;
        cause_q       <= 1'b0;
        erase_valid_q <= 1'b0;
        load_cnt_q    <= '0;
        tail_ptr_q    <= '0;
      end else begin
        case (state_q)
          LOAD: begin
            if (load_cnt_q == PW'(INIT_LEN - 1)) begin
              state_q    <= READY;
              length_q   <= LW'(INIT_LEN);
              head_xy_q  <= {YW'(INIT_Y), XW'(INIT_X)};
              head_ptr_q <= PW'(INIT_LEN - 1);
              last_dir_q <= DIR_RIGHT;
            end else begin
              load_cnt_q <= load_cnt_q + PW'(1);
            end
          end
          READY: begin
            if (step_valid) begin
              // Opposite directions differ in both bits, so their XOR is 2'b11.
              dir_q   <= (((step_dir ^ last_dir_q) == 2'b11) && (length_q > LW'(1)))
                         ? last_dir_q : step_dir;
              grow_q  <= grow;
              state_q <= CHECK;
            end
          end
          CHECK: begin
            if (wall_d) begin
              state_q        <= DEAD;
              dead_q         <= 1'b1;
              cause_q        <= 1'b0;
              erase_valid_q  <= 1'b0;
              result_valid_q <= 1'b1;
            end else begin
              new_head_q <= {ny_d, nx_d};
              scan_ptr_q <= eff_grow_d ? tail_ptr_q : ptr_inc(tail_ptr_q);
              scan_rem_q <= n_cmp_d;
              state_q    <= (n_cmp_d == '0) ? COMMIT : SCAN;
            end
          end
          SCAN: begin
            if (mem[scan_ptr_q] == new_head_q) begin
              state_q        <= DEAD;
              dead_q         <= 1'b1;
              cause_q        <= 1'b1;
              erase_valid_q  <= 1'b0;
              result_valid_q <= 1'b1;
            end else if (scan_rem_q == LW'(1)) begin
              state_q <= COMMIT;
            end else begin
              scan_ptr_q <= ptr_inc(scan_ptr_q);
              scan_rem_q <= scan_rem_q - LW'(1);
            end
          end
          COMMIT: begin
            head_ptr_q     <= ptr_inc(head_ptr_q);
            head_xy_q      <= new_head_q;
            last_dir_q     <= dir_q;
            result_valid_q <= 1'b1;
            state_q        <= READY;
            if (eff_grow_d) begin
              length_q      <= length_q + LW'(1);
              erase_valid_q <= 1'b0;
            end else begin
              erase_xy_q    <= mem[tail_ptr_q];
              tail_ptr_q    <= ptr_inc(tail_ptr_q);
              erase_valid_q <= 1'b1;
            end
          end
          IDLE, DEAD: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign step_ready   = (state_q == READY);
  assign result_valid = result_valid_q;
  assign dead         = dead_q;
  assign death_cause  = cause_q;
  assign head_xy      = head_xy_q;
  assign erase_valid  = erase_valid_q;
  assign erase_xy     = erase_xy_q;
  assign length       = length_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker: default instance plus a MAX_LEN=4 instance.
module tb_snake_body_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_s = 1'b0, step_valid_s = 1'b0, grow = 1'b0, sel = 1'b0;
  logic [1:0] step_dir = 2'd0;
  int errors = 0, checks = 0;

  logic rdy_a, rv_a, dead_a, cause_a, ev_a, rdy_b, rv_b, dead_b, cause_b, ev_b;
  logic [7:0] head_a, erase_a, head_b, erase_b;
  logic [6:0] len_a;
  logic [2:0] len_b;
  logic rdy, rv, dead, cause, ev;
  logic [7:0] head, erase;
  logic [6:0] len;

  always #5 clk = ~clk;

  snake_body_tracker u_a (
    .clk(clk), .rst_n(rst_n), .init(init_s & ~sel), .step_valid(step_valid_s & ~sel),
    .step_dir(step_dir), .grow(grow), .step_ready(rdy_a), .result_valid(rv_a),
    .dead(dead_a), .death_cause(cause_a), .head_xy(head_a), .erase_valid(ev_a),
    .erase_xy(erase_a), .length(len_a));

  snake_body_tracker #(.MAX_LEN(4)) u_b (
    .clk(clk), .rst_n(rst_n), .init(init_s & sel), .step_valid(step_valid_s & sel),
    .step_dir(step_dir), .grow(grow), .step_ready(rdy_b), .result_valid(rv_b),
    .dead(dead_b), .death_cause(cause_b), .head_xy(head_b), .erase_valid(ev_b),
    .erase_xy(erase_b), .length(len_b));

  assign rdy   = sel ? rdy_b   : rdy_a;
  assign rv    = sel ? rv_b    : rv_a;
  assign dead  = sel ? dead_b  : dead_a;
  assign cause = sel ? cause_b : cause_a;
  assign ev    = sel ? ev_b    : ev_a;
  assign head  = sel ? head_b  : head_a;
  assign erase = sel ? erase_b : erase_a;
  assign len   = sel ? 7'(len_b) : len_a;

  // n = cycles from the init cycle until step_ready is seen
  task automatic do_init(output int n);
    @(negedge clk); init_s = 1'b1;
    @(negedge clk); init_s = 1'b0;
    n = 1;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
  endtask

  // lat = cycles from the accept cycle T until result_valid is seen
  task automatic do_step(input logic [1:0] d, input logic g, output int lat);
    int w = 0;
    @(negedge clk);
    while (!rdy && w < 50) begin @(negedge clk); w++; end
    step_valid_s = 1'b1; step_dir = d; grow = g;
    @(negedge clk); step_valid_s = 1'b0;
    lat = 1;
    while (!rv && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({rdy_a, rv_a, dead_a, cause_a, ev_a, head_a, erase_a, len_a} !== '0) begin
      errors++; $display("FAIL reset_a: got rdy=%b rv=%b dead=%b head=%h erase=%h len=%0d, want all 0",
                         rdy_a, rv_a, dead_a, head_a, erase_a, len_a);
    end
    checks++;
    if ({rdy_b, rv_b, dead_b, cause_b, ev_b, head_b, erase_b, len_b} !== '0) begin
      errors++; $display("FAIL reset_b: outputs not all 0 (head=%h len=%0d)", head_b, len_b);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_init;
    int n;
    do_init(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL init_ready_delay: got %0d want 4", n); end
    checks++; if (head !== 8'h84) begin errors++; $display("FAIL init_head: got %h want 84", head); end
    checks++; if (len !== 7'd3) begin errors++; $display("FAIL init_len: got %0d want 3", len); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL init_dead: got %b want 0", dead); end
  endtask

  task automatic test_step_right;
    int lat;
    do_step(2'd0, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL right_lat: got %0d want 5", lat); end
    checks++; if (head !== 8'h85) begin errors++; $display("FAIL right_head: got %h want 85", head); end
    checks++;
    if ({ev, erase} !== {1'b1, 8'h82}) begin
      errors++; $display("FAIL right_erase: got ev=%b xy=%h want ev=1 xy=82", ev, erase);
    end
    checks++; if (len !== 7'd3) begin errors++; $display("FAIL right_len: got %0d want 3", len); end
  endtask

  task automatic test_grow_reversal;
    int lat;
    do_step(2'd1, 1'b1, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL grow_lat: got %0d want 6", lat); end
    checks++;
    if ({head, ev, len} !== {8'h95, 1'b0, 7'd4}) begin
      errors++; $display("FAIL grow_state: got head=%h ev=%b len=%0d want 95/0/4", head, ev, len);
    end
    do_step(2'd2, 1'b0, lat);
    checks++;
    if ({head, ev, erase, len} !== {8'hA5, 1'b1, 8'h83, 7'd4}) begin
      errors++; $display("FAIL reversal: got head=%h ev=%b erase=%h len=%0d want A5/1/83/4",
                         head, ev, erase, len);
    end
  endtask

  task automatic test_tail_chase;
    logic [1:0] dirs  [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
    logic [7:0] heads [4] = '{8'hA6, 8'h96, 8'h95, 8'hA5};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_step(dirs[i], 1'b0, lat);
      checks++;
      if ({lat == 6, dead, head} !== {1'b1, 1'b0, heads[i]}) begin
        errors++; $display("FAIL tail_chase_%0d: got lat=%0d dead=%b head=%h want 6/0/%h",
                           i, lat, dead, head, heads[i]);
      end
    end
  endtask

  task automatic test_self_hit;
    int lat;
    do_step(2'd1, 1'b1, lat);
    checks++;
    if ({lat == 7, head, len} !== {1'b1, 8'hB5, 7'd5}) begin
      errors++; $display("FAIL self_grow: got lat=%0d head=%h len=%0d want 7/B5/5", lat, head, len);
    end
    do_step(2'd3, 1'b0, lat);
    do_step(2'd2, 1'b0, lat);
    checks++;
    if ({head, dead} !== {8'hA4, 1'b0}) begin
      errors++; $display("FAIL self_pre: got head=%h dead=%b want A4/0", head, dead);
    end
    do_step(2'd0, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL self_lat: got %0d want 3", lat); end
    checks++;
    if ({dead, cause, head, len, ev} !== {1'b1, 1'b1, 8'hA4, 7'd5, 1'b0}) begin
      errors++; $display("FAIL self_dead: got dead=%b cause=%b head=%h len=%0d want 1/1/A4/5",
                         dead, cause, head, len);
    end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL self_ready: got %b want 0", rdy); end
  endtask

  task automatic test_wall;
    int n, lat, bad = 0, pulses = 0;
    do_init(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL wall_init: got %0d want 4", n); end
    for (int i = 0; i < 11; i++) begin
      do_step(2'd0, 1'b0, lat);
      if (lat != 5 || dead) bad++;
    end
    checks++;
    if ({bad == 0, head} !== {1'b1, 8'h8F}) begin
      errors++; $display("FAIL wall_run: got bad=%0d head=%h want 0/8F", bad, head);
    end
    do_step(2'd0, 1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wall_lat: got %0d want 2", lat); end
    checks++;
    if ({dead, cause, head, len} !== {1'b1, 1'b0, 8'h8F, 7'd3}) begin
      errors++; $display("FAIL wall_dead: got dead=%b cause=%b head=%h len=%0d want 1/0/8F/3",
                         dead, cause, head, len);
    end
    step_valid_s = 1'b1; step_dir = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv || rdy) pulses++;
    end
    step_valid_s = 1'b0;
    checks++;
    if ({pulses == 0, dead, head} !== {1'b1, 1'b1, 8'h8F}) begin
      errors++; $display("FAIL dead_ignore: got pulses=%0d dead=%b head=%h want 0/1/8F", pulses, dead, head);
    end
  endtask

  task automatic test_init_mid_scan;
    int n, pulses = 0;
    do_init(n);
    @(negedge clk);
    step_valid_s = 1'b1; step_dir = 2'd0; grow = 1'b0;
    @(negedge clk); step_valid_s = 1'b0;
    @(negedge clk); init_s = 1'b1;
    @(negedge clk); init_s = 1'b0;
    n = 1;
    while (!rdy && n < 50) begin
      if (rv) pulses++;
      @(negedge clk); n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (rv) pulses++;
      @(negedge clk);
    end
    checks++;
    if ({n == 4, pulses == 0} !== 2'b11) begin
      errors++; $display("FAIL mid_scan_init: got ready_delay=%0d pulses=%0d want 4/0", n, pulses);
    end
    checks++;
    if ({head, len, dead} !== {8'h84, 7'd3, 1'b0}) begin
      errors++; $display("FAIL mid_scan_restore: got head=%h len=%0d dead=%b want 84/3/0", head, len, dead);
    end
  endtask

  task automatic test_maxlen;
    int n, lat;
    sel = 1'b1;
    do_init(n);
    checks++; if ({n == 4, head} !== {1'b1, 8'h84}) begin
      errors++; $display("FAIL ml_init: got n=%0d head=%h want 4/84", n, head); end
    do_step(2'd1, 1'b1, lat);
    checks++;
    if ({lat == 6, head, len, ev} !== {1'b1, 8'h94, 7'd4, 1'b0}) begin
      errors++; $display("FAIL ml_grow: got lat=%0d head=%h len=%0d ev=%b want 6/94/4/0", lat, head, len, ev);
    end
    do_step(2'd1, 1'b1, lat);
    checks++;
    if ({lat == 6, head, len, ev, erase} !== {1'b1, 8'hA4, 7'd4, 1'b1, 8'h82}) begin
      errors++; $display("FAIL ml_full_grow: got lat=%0d head=%h len=%0d ev=%b erase=%h want 6/A4/4/1/82",
                         lat, head, len, ev, erase);
    end
    do_step(2'd0, 1'b0, lat);
    checks++;
    if ({head, erase, len} !== {8'hA5, 8'h83, 7'd4}) begin
      errors++; $display("FAIL ml_wrap1: got head=%h erase=%h len=%0d want A5/83/4", head, erase, len);
    end
    do_step(2'd0, 1'b0, lat);
    checks++;
    if ({head, erase, dead} !== {8'hA6, 8'h84, 1'b0}) begin
      errors++; $display("FAIL ml_wrap2: got head=%h erase=%h dead=%b want A6/84/0", head, erase, dead);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_commit;
    int n;
    do_init(n);
    @(negedge clk);
    step_valid_s = 1'b1; step_dir = 2'd0; grow = 1'b0;
    @(negedge clk); step_valid_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_a, rv_a, dead_a, cause_a, ev_a, head_a, erase_a, len_a} !== '0) begin
      errors++; $display("FAIL reset_commit: got head=%h len=%0d ev=%b erase=%h rv=%b want all 0",
                         head_a, len_a, ev_a, erase_a, rv_a);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_init;
    test_step_right;
    test_grow_reversal;
    test_tail_chase;
    test_self_hit;
    test_wall;
    test_init_mid_scan;
    test_maxlen;
    test_reset_mid_commit;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
